// File: rtl/cpu_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes, FSM states
// and datapath select values.
package cpu_mc_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIllegal = 4'd10
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Opcode classifier: maps IR[31:26] onto a one-hot instruction class.
module mc_opcode_decode
    import cpu_mc_pkg::*;
(
    input  logic [5:0] op,
    output logic       is_r,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_j,
    output logic       is_illegal
);

    always_comb begin
        is_r       = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_R:    is_r       = 1'b1;
            OP_LW:   is_lw      = 1'b1;
            OP_SW:   is_sw      = 1'b1;
            OP_BEQ:  is_beq     = 1'b1;
            OP_J:    is_j       = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_mc_controller.sv
// Moore-style multi-cycle control FSM for the shared-ALU/shared-memory MIPS-subset
// datapath, with memory ready stalls, illegal-opcode trap and retired-instruction counter.
module cpu_mc_controller
    import cpu_mc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           op,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [3:0]           state,
    output logic                 instr_done,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired_count
);

    state_e               state_q, state_d;
    ctrl_t                ctrl, ctrl_out;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 is_r, is_lw, is_sw, is_beq, is_j, is_illegal;
    logic [5:0]           op_class;

    mc_opcode_decode u_decode (
        .op         (op),
        .is_r       (is_r),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_j       (is_j),
        .is_illegal (is_illegal)
    );

    assign op_class = {is_r, is_lw, is_sw, is_beq, is_j, is_illegal};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                unique case (op_class)
                    6'b100000: state_d = StExec;
                    6'b010000: state_d = StMemAdr;
                    6'b001000: state_d = StMemAdr;
                    6'b000100: state_d = StBranch;
                    6'b000010: state_d = StJump;
                    default:   state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_d        = is_lw ? StMemRd : StMemWr;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = StFetch;
            end
            StMemWr: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = StAluWb;
            end
            StAluWb: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = StFetch;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                state_d            = StFetch;
            end
            StJump: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
                state_d         = StFetch;
            end
            StIllegal: begin
                ctrl.illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset forces every output low combinationally, not just from the next edge.
    assign ctrl_out = rst ? '0 : ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (ctrl_out.instr_done) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_source     = ctrl_out.pc_source;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign instr_done    = ctrl_out.instr_done;
    assign illegal       = ctrl_out.illegal;
    assign state         = state_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_cpu_mc_controller.sv
// Bench for cpu_mc_controller: directed scenarios plus random instruction streams,
// checked against an instruction-level step-plan model (32-bit and 4-bit counter instances).
module tb_cpu_mc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic mem_ready = 1'b0;

    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;
    logic [31:0] cnt32;

    logic pc_write_4, pc_write_cond_4, i_or_d_4, mem_read_4, mem_write_4, ir_write_4;
    logic mem_to_reg_4, reg_dst_4, reg_write_4, alu_src_a_4, instr_done_4, illegal_4;
    logic [1:0] pc_source_4, alu_src_b_4, alu_op_4;
    logic [3:0] state_4;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    cpu_mc_controller #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .instr_done(instr_done), .illegal(illegal), .retired_count(cnt32)
    );

    cpu_mc_controller #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write_4), .pc_write_cond(pc_write_cond_4), .pc_source(pc_source_4),
        .i_or_d(i_or_d_4), .mem_read(mem_read_4), .mem_write(mem_write_4),
        .ir_write(ir_write_4), .mem_to_reg(mem_to_reg_4), .reg_dst(reg_dst_4),
        .reg_write(reg_write_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
        .alu_op(alu_op_4), .state(state_4), .instr_done(instr_done_4),
        .illegal(illegal_4), .retired_count(cnt4)
    );

    wire [17:0] vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                       alu_op, instr_done, illegal};
    wire [17:0] vec4 = {pc_write_4, pc_write_cond_4, pc_source_4, i_or_d_4, mem_read_4,
                        mem_write_4, ir_write_4, mem_to_reg_4, reg_dst_4, reg_write_4,
                        alu_src_a_4, alu_src_b_4, alu_op_4, instr_done_4, illegal_4};

    int total = 0;
    int bad = 0;

    // Model: current step number, remaining steps of the instruction, retire count.
    int          m_state = 0;
    int          plan[$];
    int unsigned m_cnt = 0;

    function automatic logic [17:0] exp_ctrl(int s, logic rdy, logic r);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, done, ill;
        logic [1:0] ps, sb, ao;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, done, ill} = '0;
        ps = 2'b00; sb = 2'b00; ao = 2'b00;
        if (!r) begin
            case (s)
                0: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
                1: sb = 2'b11;
                2: begin sa = 1; sb = 2'b10; end
                3: begin mr = 1; iod = 1; end
                4: begin rw = 1; m2r = 1; done = 1; end
                5: begin mw = 1; iod = 1; done = rdy; end
                6: begin sa = 1; ao = 2'b10; end
                7: begin rd = 1; rw = 1; done = 1; end
                8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
                9: begin pw = 1; ps = 2'b10; done = 1; end
                10: ill = 1;
                default: ;
            endcase
        end
        return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, done, ill};
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        logic [17:0] e;
        e = exp_ctrl(m_state, mem_ready, rst);
        chk({tag, "/ctrl"}, {14'd0, vec}, {14'd0, e});
        chk({tag, "/ctrl4"}, {14'd0, vec4}, {14'd0, e});
        chk({tag, "/state"}, {28'd0, state}, m_state);
        chk({tag, "/cnt32"}, cnt32, m_cnt);
        chk({tag, "/cnt4"}, {28'd0, cnt4}, m_cnt % 16);
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance model and DUT.
    task automatic cycle(string tag, logic [5:0] op_v, logic rdy);
        int nxt;
        op = op_v;
        mem_ready = rdy;
        #3;
        check_all(tag);
        nxt = m_state;
        case (m_state)
            0: if (rdy) nxt = 1;
            1: begin
                case (op_v)
                    6'b100011: plan = '{2, 3, 4};
                    6'b101011: plan = '{2, 5};
                    6'b000000: plan = '{6, 7};
                    6'b000100: plan = '{8};
                    6'b000010: plan = '{9};
                    default:   plan = '{10};
                endcase
                nxt = plan.pop_front();
            end
            3, 5: if (rdy) nxt = (plan.size() != 0) ? plan.pop_front() : 0;
            10: nxt = 10;
            default: nxt = (plan.size() != 0) ? plan.pop_front() : 0;
        endcase
        if (m_state inside {4, 7, 8, 9} || (m_state == 5 && rdy)) m_cnt++;
        m_state = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        #1;
        m_state = 0;
        m_cnt = 0;
        plan.delete();
        check_all({tag, "/async"});
        @(posedge clk);
        #1;
        check_all({tag, "/held"});
        rst = 1'b0;
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;

    initial begin
        logic [5:0] cur_op;
        logic [5:0] bad_ops [4];
        int ill_cycles;
        bad_ops = '{6'h3F, 6'h01, 6'h08, 6'h2A};

        #2;
        do_reset("reset");

        repeat (5) cycle("lw", LW, 1'b1);
        repeat (4) cycle("r", RT, 1'b1);
        repeat (3) cycle("beq", BEQ, 1'b1);
        repeat (3) cycle("j", JMP, 1'b1);
        chk("count_after_4", cnt32, 32'd4);

        cycle("sw_stall", SW, 1'b0);
        cycle("sw_stall", SW, 1'b0);
        cycle("sw_stall", SW, 1'b1);
        cycle("sw_stall", SW, 1'b1);
        cycle("sw_stall", SW, 1'b1);
        cycle("sw_stall", SW, 1'b0);
        cycle("sw_stall", SW, 1'b0);
        cycle("sw_stall", SW, 1'b1);
        chk("count_after_sw", cnt32, 32'd5);

        repeat (22) cycle("illegal", 6'b111111, 1'($urandom_range(0, 1)));
        chk("illegal_sticky", {28'd0, state}, 32'd10);
        do_reset("after_illegal");

        repeat (3) cycle("lw_abort", LW, 1'b1);
        cycle("lw_abort", LW, 1'b0);
        do_reset("abort");

        repeat (51) cycle("j_wrap", JMP, 1'b1);
        chk("wrap4", {28'd0, cnt4}, 32'd1);

        cur_op = LW;
        ill_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            if (m_state == 10 && ill_cycles >= 4) begin
                do_reset("rand_rst");
                ill_cycles = 0;
            end else begin
                if (m_state == 0) begin
                    case ($urandom_range(0, 9))
                        0, 1:    cur_op = LW;
                        2, 3:    cur_op = SW;
                        4, 5:    cur_op = RT;
                        6:       cur_op = BEQ;
                        7, 8:    cur_op = JMP;
                        default: cur_op = bad_ops[$urandom_range(0, 3)];
                    endcase
                end
                if (m_state == 10) ill_cycles++;
                cycle("rand", cur_op, 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mc_controller.md
Name: cpu_mc_controller

Overview:
Multi-cycle control unit for the MIPS-subset CPU: R-type, LW, SW, BEQ and J.
It sequences a shared-ALU, shared-memory datapath through a Moore FSM, with one datapath step per clock.
It stalls memory states on a ready handshake, traps illegal opcodes, and counts retired instructions.
It drives the datapath mux selects and write enables directly.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  6  opcode field, IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  register write data from MDR
reg_dst  out  1  destination register: 1 rd, 0 rt
reg_write  out  1  register file write
alu_src_a  out  1  ALU A input: 0 PC, 1 register A
alu_src_b  out  2  ALU B input: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
state  out  4  current state encoding, for debug
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  trapped on an unsupported opcode
retired_count  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: state=FETCH (0), retired_count=0. While rst=1, every control output is 0, including instr_done and illegal.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010. Anything else is illegal.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ILLEGAL=10. Encodings 11–15 go to FETCH on the next clock and drive all outputs 0.
- Outputs are combinational from state (plus mem_ready where noted). Any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00. Next state by op:
  - LW or SW → MEMADR
  - R → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - other → ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10. Next is MEMRD if op=LW, MEMWR if op=SW.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH. mem_write stays asserted throughout the stall.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next is FETCH.
- JUMP: pc_write=1, pc_source=10. Next is FETCH.
- ILLEGAL:
  - illegal=1; all write enables and strobes are 0.
  - Sticky until rst; no exit on any input.
- instr_done=1 in these cycles only:
  - MEMWB, ALUWB, BRANCH, JUMP;
  - MEMWR in its mem_ready=1 cycle.
- retired_count increments on each clock edge where instr_done=1. It wraps from all-ones to 0.
- Latency with mem_ready held at 1:
  - LW: 5 cycles
  - R and SW: 4 cycles
  - BEQ and J: 3 cycles
  - Each stall cycle adds 1.
- rst asserted mid-instruction aborts it immediately: no instr_done and no counter increment for the aborted instruction.

Decomposition:
- Shared package cpu_mc_pkg holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J);
  - the state enum with the encodings above;
  - ALUOp constants (ALU_ADD, ALU_SUB, ALU_FUNCT);
  - pc_source and alu_src_b select constants.
- One sub-module, mc_opcode_decode: combinational op → one-hot {is_r, is_lw, is_sw, is_beq, is_j, is_illegal}.
- The FSM, output decode and counter stay in cpu_mc_controller.

Test Plan:
- LW, mem_ready=1 throughout → state sequence 0,1,2,3,4,0. reg_write=mem_to_reg=1 only in state 4. instr_done pulses once. retired_count 0→1.
- R then BEQ then J, mem_ready=1 → sequences 0,1,6,7 / 0,1,8 / 0,1,9. pc_write_cond=1 only in state 8, pc_source=10 in state 9. retired_count=3 after 10 cycles.
- mem_ready=0 for 2 cycles in FETCH, then in MEMWR of an SW → FETCH held 3 cycles with ir_write/pc_write high only in the third. MEMWR held 3 cycles with mem_write=1 throughout. instr_done only in the last MEMWR cycle.
- op=111111 → DECODE, then ILLEGAL. illegal=1 held 20 cycles. pc_write, reg_write, mem_write, ir_write all 0. retired_count unchanged.
- rst pulsed while in MEMRD with mem_ready=0 → outputs 0 immediately, state=0, retired_count=0. After release, FETCH outputs resume on the first cycle.
- CNT_WIDTH=4, 17 back-to-back J instructions → retired_count wraps 15→0→1.
